// File: rtl/cc_unit.sv
// Y86-64 execute-stage condition codes: derives ZF/SF/OF from the ALU,
// holds them in the CC register and evaluates cnd for jXX/cmovXX in E.
module cc_unit #(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   e_icode,
    input  logic [3:0]   e_ifun,
    input  logic [N-1:0] alu_a,
    input  logic [N-1:0] alu_b,
    input  logic [N-1:0] alu_out,
    input  logic         m_exc,
    input  logic         w_exc,
    input  logic         stall,
    output logic         zf,
    output logic         sf,
    output logic         of,
    output logic         cnd,
    output logic         set_cc
);

    localparam logic [3:0] I_OPQ = 4'd6;

    logic sa, sb, so;
    logic nzf, nsf, nof;

    assign sa = alu_a[N-1];
    assign sb = alu_b[N-1];
    assign so = alu_out[N-1];

    // ifun above 3 is an illegal OPq; decode reports INS, CC must not move
    assign set_cc = (e_icode == I_OPQ) & (e_ifun[3:2] == 2'b00)
                  & ~m_exc & ~w_exc & ~stall;

    always_comb begin
        nzf = (alu_out == '0);
        nsf = so;
        nof = 1'b0;
        case (e_ifun[1:0])
            2'd0:    nof = (sa == sb) & (so != sb);
            2'd1:    nof = (sa != sb) & (so != sb);
            default: nof = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zf <= 1'b1;
            sf <= 1'b0;
            of <= 1'b0;
        end else if (set_cc) begin
            zf <= nzf;
            sf <= nsf;
            of <= nof;
        end
    end

    // Evaluated from registered flags only: the OPq currently in E never bypasses
    always_comb begin
        cnd = 1'b0;
        case (e_ifun)
            4'd0:    cnd = 1'b1;
            4'd1:    cnd = (sf ^ of) | zf;
            4'd2:    cnd = sf ^ of;
            4'd3:    cnd = zf;
            4'd4:    cnd = ~zf;
            4'd5:    cnd = ~(sf ^ of);
            4'd6:    cnd = ~(sf ^ of) & ~zf;
            default: cnd = 1'b0;
        endcase
    end

endmodule
